or1200_cl_pad_engine: RTL
=========================

OR1200_CL_PAD_ENGINE -- requirements
Module: or1200_cl_pad_engine

Interface
REQ-001 Parameter NUM_CH, default 2, meaning 128-bit pads generated per cache line; legal values 1..8.
REQ-002 Parameter SEED_W, default 28, meaning seed tag width; SEED_W + CH_W SHALL be at most 128, where CH_W = max(1, clog2(NUM_CH)).
REQ-003 Port clk, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1, asynchronous, active-low reset.
REQ-005 Port req, input, 1, cache-line encryption request (tag miss with encryption evaluated).
REQ-006 Port secure_exec, input, 1, secure mode qualifier.
REQ-007 Port smc_hit, input, 1, secure memory region hit.
REQ-008 Port dmmu_ci, input, 1, cache-inhibit; blocks the request.
REQ-009 Port flush, input, 1, invalidates buffered pads and aborts any run in progress.
REQ-010 Port enc_key, input, 128, AES key.
REQ-011 Port seed_tag, input, SEED_W, line tag used to build seeds.
REQ-012 Port enc_on, output, 1, high while the engine is busy.
REQ-013 Port enc_done, output, 1, one-cycle pulse when all pads are valid.
REQ-014 Port pad_hit, output, 1, high together with enc_done when the request was served from buffered pads.
REQ-015 Port pad_valid, output, 1, pad buffer holds pads for last_tag/last_key.
REQ-016 Port pad_out, output, NUM_CH*128, pad buffer; channel i occupies bits [128*i+127 : 128*i].

Function
REQ-017 start SHALL equal req & secure_exec & smc_hit & !dmmu_ci, and SHALL be sampled only in IDLE; start outside IDLE SHALL be ignored.
REQ-018 The seed for channel i SHALL be {zero fill, seed_tag, i as CH_W bits}, 128 bits total.
REQ-019 FSM states SHALL be IDLE, LOAD, WAIT, DRAIN and DONE.
REQ-020 IDLE, reuse case: start with pad_valid=1, seed_tag==last_tag and enc_key==last_key SHALL go to DONE with pad_hit set and no core activity.
REQ-021 IDLE, miss case: start without a reuse match SHALL latch seed_tag and enc_key, clear pad_valid, set ch_idx=0 and go to LOAD.
REQ-022 LOAD SHALL assert core ld for exactly one cycle with seed(ch_idx), then go to WAIT.
REQ-023 WAIT, on core done, SHALL write the core output into pad_out channel ch_idx.
REQ-024 From WAIT, after that write, the FSM SHALL go to LOAD with ch_idx+1 if ch_idx < NUM_CH-1, and otherwise go to DONE with pad_valid set.
REQ-025 DONE SHALL assert enc_done for exactly one cycle, then return to IDLE.
REQ-026 Miss latency: with core latency L (done L cycles after ld), start sampled in cycle T SHALL produce enc_done in cycle T + NUM_CH*(L+1) + 1.
REQ-027 Hit latency: enc_done SHALL be asserted in cycle T+1.
REQ-028 enc_on SHALL be high in LOAD, WAIT, DRAIN and DONE, and low in IDLE.
REQ-029 flush in IDLE or DONE SHALL clear pad_valid, and an enc_done already in DONE SHALL still be issued with pad_hit=0.
REQ-030 flush in LOAD SHALL go to DRAIN after the ld is issued.
REQ-031 flush in WAIT SHALL go to DRAIN, or straight to IDLE if core done arrives in the same cycle.
REQ-032 DRAIN SHALL wait for core done, discard the result, issue no enc_done, and return to IDLE.
REQ-033 flush with start in the same IDLE cycle: flush SHALL win and the request is dropped.
REQ-034 pad_out SHALL be stable whenever pad_valid=1.
REQ-035 Partially written pad_out SHALL NOT be reported valid.

Reset
REQ-036 While rst=0, the FSM SHALL be IDLE, ch_idx=0 and every output 0 (including pad_out); last_tag and last_key SHALL be 0.
REQ-037 Reset mid-run SHALL abandon the run without issuing enc_done.
REQ-038 Reset release SHALL take effect at the next rising clk edge.

Structure
REQ-039 The FSM state encoding, the 128-bit block width constant and the CH_W derivation SHALL reside in a shared package, or1200_cl_enc_pkg.
REQ-040 One sub-module, aes_cipher_wrapper (ld/done/key/text_in/text_out), SHALL be instantiated once and time-multiplexed across channels.
REQ-041 No second clock domain SHALL exist.

Verification
REQ-042 Stub rule for all scenarios: the bench SHALL replace the core with a stub giving done L=12 cycles after ld and text_out = text_in ^ key.
REQ-043 Miss run: NUM_CH=2, key=0, seed_tag=28'h0ABCDEF, start at cycle 0 -> enc_done at cycle 27, pad_valid=1, channel0 = {..,0ABCDEF,0}, channel1 = {..,0ABCDEF,1}, enc_on high cycles 1-27.
REQ-044 Reuse: repeat the same request after REQ-043 -> enc_done at T+1, pad_hit=1, no ld observed.
REQ-045 Key change: same tag, key=128'h1 -> full miss, both pads XOR 1, pad_hit=0.
REQ-046 Flush mid-run: flush in the first WAIT -> DRAIN, no enc_done, pad_valid=0, IDLE 13 or fewer cycles later, and a following request performs a full miss.
REQ-047 Gating and reset: dmmu_ci=1 or smc_hit=0 -> no activity; rst=0 during WAIT -> all outputs 0, and no enc_done after release.
REQ-048 NUM_CH=4 run: enc_done at T+53 and four distinct channel indices present in the seeds.

Source files
------------

// File: rtl/or1200_cl_enc_pkg.sv
// Shared definitions for the cache-line pad engine: block width, core latency,
// controller state encoding and channel-index width derivation.
package or1200_cl_enc_pkg;

  localparam int unsigned BLOCK_W  = 128;
  localparam int unsigned CORE_LAT = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Channel index width: at least one bit even for a single channel.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/aes_cipher_wrapper.sv
// Block-cipher core boundary: fixed-latency model that returns
// text_in ^ key exactly LATENCY cycles after ld.
module aes_cipher_wrapper
  import or1200_cl_enc_pkg::*;
#(
  parameter int unsigned LATENCY = CORE_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic [BLOCK_W-1:0] key,
  input  logic [BLOCK_W-1:0] text_in,
  output logic               done,
  output logic [BLOCK_W-1:0] text_out
);

  logic [LATENCY-1:0] pipe_q;
  logic [BLOCK_W-1:0] text_q;

  // Token shift line times the result; payload is captured at load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= '0;
      text_q <= '0;
    end else begin
      pipe_q <= {pipe_q[LATENCY-2:0], ld};
      if (ld) text_q <= text_in ^ key;
    end
  end

  assign done     = pipe_q[LATENCY-1];
  assign text_out = text_q;

endmodule

// File: rtl/or1200_cl_pad_engine.sv
// Cache-line pad engine: builds NUM_CH 128-bit pads from the line tag through a
// single time-multiplexed cipher core, reusing buffered pads on a tag/key match.
module or1200_cl_pad_engine
  import or1200_cl_enc_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned SEED_W = 28
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic                      secure_exec,
  input  logic                      smc_hit,
  input  logic                      dmmu_ci,
  input  logic                      flush,
  input  logic [BLOCK_W-1:0]        enc_key,
  input  logic [SEED_W-1:0]         seed_tag,
  output logic                      enc_on,
  output logic                      enc_done,
  output logic                      pad_hit,
  output logic                      pad_valid,
  output logic [NUM_CH*BLOCK_W-1:0] pad_out
);

  localparam int unsigned CH_W = ch_width(NUM_CH);

  state_e                          state_q, state_d;
  logic [CH_W-1:0]                 ch_idx_q, ch_idx_d;
  logic                            pad_valid_q, pad_valid_d;
  logic [NUM_CH-1:0][BLOCK_W-1:0]  pad_q;
  logic [SEED_W-1:0]               last_tag_q;
  logic [BLOCK_W-1:0]              last_key_q;
  logic                            enc_on_q, enc_done_q, pad_hit_q;

  logic                            start_c, reuse_c, last_ch_c;
  logic                            hit_c, latch_c, pad_we_c, core_ld;
  logic                            core_done;
  logic [BLOCK_W-1:0]              core_text, seed_c;

  assign start_c   = req & secure_exec & smc_hit & ~dmmu_ci;
  assign reuse_c   = pad_valid_q && (seed_tag == last_tag_q) && (enc_key == last_key_q);
  assign last_ch_c = (ch_idx_q == CH_W'(NUM_CH - 1));
  assign seed_c    = BLOCK_W'({last_tag_q, ch_idx_q});

  aes_cipher_wrapper #(.LATENCY(CORE_LAT)) u_core (
    .clk      (clk),
    .rst      (rst),
    .ld       (core_ld),
    .key      (last_key_q),
    .text_in  (seed_c),
    .done     (core_done),
    .text_out (core_text)
  );

  // Next-state and per-cycle control.
  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    pad_valid_d = pad_valid_q;
    hit_c       = 1'b0;
    latch_c     = 1'b0;
    pad_we_c    = 1'b0;
    core_ld     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush) begin
          pad_valid_d = 1'b0;
        end else if (start_c) begin
          if (reuse_c) begin
            hit_c   = 1'b1;
            state_d = ST_DONE;
          end else begin
            latch_c     = 1'b1;
            pad_valid_d = 1'b0;
            ch_idx_d    = '0;
            state_d     = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        core_ld = 1'b1;
        state_d = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = core_done ? ST_IDLE : ST_DRAIN;
        end else if (core_done) begin
          pad_we_c = 1'b1;
          if (last_ch_c) begin
            pad_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            ch_idx_d = ch_idx_q + CH_W'(1);
            state_d  = ST_LOAD;
          end
        end
      end
      // In-flight result is thrown away once it arrives.
      ST_DRAIN: begin
        if (core_done) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (flush) pad_valid_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ch_idx_q    <= '0;
      pad_valid_q <= 1'b0;
      pad_q       <= '0;
      last_tag_q  <= '0;
      last_key_q  <= '0;
      enc_on_q    <= 1'b0;
      enc_done_q  <= 1'b0;
      pad_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= ch_idx_d;
      pad_valid_q <= pad_valid_d;
      enc_on_q    <= (state_d != ST_IDLE);
      enc_done_q  <= (state_d == ST_DONE);
      pad_hit_q   <= hit_c;
      if (latch_c) begin
        last_tag_q <= seed_tag;
        last_key_q <= enc_key;
      end
      if (pad_we_c) pad_q[ch_idx_q] <= core_text;
    end
  end

  assign enc_on    = enc_on_q;
  assign enc_done  = enc_done_q;
  // A flush landing on the completion cycle withdraws the hit indication.
  assign pad_hit   = pad_hit_q & ~flush;
  assign pad_valid = pad_valid_q;
  assign pad_out   = pad_q;

endmodule
